// File: rtl/fcvt_arbiter_pkg.sv
// Shared types and constants for the FCVT sequencing/sharing controller.
package fcvt_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // {funct7[3], rs2[0]} selects the conversion flavour.
    localparam logic [1:0] OP_W_S  = 2'b00;
    localparam logic [1:0] OP_WU_S = 2'b01;
    localparam logic [1:0] OP_S_W  = 2'b10;
    localparam logic [1:0] OP_S_WU = 2'b11;

endpackage

// File: rtl/fcvt_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is accepted.
module fcvt_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       idx_o
);

    logic last_q;
    logic last_d;
    logic accept;

    // On contention the requester that did not win last time goes first.
    assign idx_o  = req_i[1] & ~(req_i[0] & last_q);
    assign accept = en_i & (|req_i);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (accept) begin
            gnt_o  = idx_o ? 2'b10 : 2'b01;
            last_d = idx_o;
        end
    end

    // NOTE: state flops use non-blocking assignments; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fcvt_arbiter.sv
// Shares one combinational FCVT datapath between two requesters with a
// registered operand stage and a valid/ready response register.
module fcvt_arbiter
    import fcvt_arbiter_pkg::*;
#(
    parameter int FLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [FLEN-1:0]  req0_rs1,
    input  logic             req0_rs2_0,
    input  logic             req0_funct7_3,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [FLEN-1:0]  req1_rs1,
    input  logic             req1_rs2_0,
    input  logic             req1_funct7_3,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             cvt_en,
    output logic [FLEN-1:0]  cvt_rs1,
    output logic             cvt_rs2_0,
    output logic             cvt_funct7_3,
    input  logic [FLEN-1:0]  cvt_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [FLEN-1:0]  rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_src,
    output logic             busy
);

    state_e state_q, state_d;

    logic             eligible;
    logic [1:0]       gnt;
    logic             gnt_idx;
    logic             grant;

    logic [FLEN-1:0]  op_rs1_q;
    logic             op_rs2_0_q;
    logic             op_funct7_3_q;
    logic [TAG_W-1:0] op_tag_q;
    logic             op_src_q;

    logic             rsp_valid_q;
    logic [FLEN-1:0]  rsp_result_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             rsp_src_q;

    // A new operation may start only when the response slot is free or draining.
    assign eligible = rst_n && !flush &&
                      ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));

    fcvt_rr_arb2 u_arb (
        .clk   (CLK),
        .rst_n (rst_n),
        .en_i  (eligible),
        .req_i ({req1_valid, req0_valid}),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign grant      = |gnt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = grant ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n || flush) begin
            op_rs1_q      <= '0;
            op_rs2_0_q    <= 1'b0;
            op_funct7_3_q <= 1'b0;
            op_tag_q      <= '0;
            op_src_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_tag_q     <= '0;
            rsp_src_q     <= 1'b0;
        end else begin
            if (grant) begin
                op_rs1_q      <= gnt_idx ? req1_rs1      : req0_rs1;
                op_rs2_0_q    <= gnt_idx ? req1_rs2_0    : req0_rs2_0;
                op_funct7_3_q <= gnt_idx ? req1_funct7_3 : req0_funct7_3;
                op_tag_q      <= gnt_idx ? req1_tag      : req0_tag;
                op_src_q      <= gnt_idx;
            end
            if (state_q == ST_EXEC) begin
                rsp_result_q <= cvt_result;
                rsp_tag_q    <= op_tag_q;
                rsp_src_q    <= op_src_q;
            end
            rsp_valid_q <= (state_d == ST_RESP);
        end
    end

    // Operands are gated to zero outside EXEC so the datapath stays quiet.
    assign cvt_en       = (state_q == ST_EXEC);
    assign cvt_rs1      = cvt_en ? op_rs1_q : '0;
    assign cvt_rs2_0    = cvt_en & op_rs2_0_q;
    assign cvt_funct7_3 = cvt_en & op_funct7_3_q;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_src    = rsp_src_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/fcvt_arbiter.md
# fcvt_arbiter

Sequencing and sharing controller for the combinational float/integer conversion datapath (FCVT.W.S, FCVT.WU.S, FCVT.S.W, FCVT.S.WU). Two requesters share one conversion unit: port 0 is the FP issue slot and port 1 is the microcode/trap-assist slot. The block arbitrates round-robin, registers the operands, and drives the datapath from those registers. It captures the result into a response register with a valid/ready handshake and supports a pipeline flush.

## Interface
Parameters:
- FLEN, 32, operand/result width
- TAG_W, 5, requester tag width (destination register index)

Ports:
- CLK, in, 1, clock; all state updates on the rising edge
- rst_n, in, 1, reset; synchronous, active-low
- flush, in, 1, discard in-flight and buffered operation
- req0_valid / req1_valid, in, 1, request present
- req0_ready / req1_ready, out, 1, request accepted this cycle when valid&&ready
- req0_rs1 / req1_rs1, in, FLEN, source operand
- req0_rs2_0 / req1_rs2_0, in, 1, rs2[0] (unsigned select)
- req0_funct7_3 / req1_funct7_3, in, 1, funct7[3] (direction: 1 = int→float)
- req0_tag / req1_tag, in, TAG_W, opaque tag returned with result
- cvt_en, out, 1, datapath enable
- cvt_rs1, out, FLEN, datapath operand
- cvt_rs2_0 / cvt_funct7_3, out, 1, datapath op select
- cvt_result, in, FLEN, datapath combinational result
- rsp_valid, out, 1, response available
- rsp_ready, in, 1, consumer accepts response
- rsp_result, out, FLEN, converted value
- rsp_tag, out, TAG_W, tag of the completed request
- rsp_src, out, 1, requester index that issued it
- busy, out, 1, high in EXEC or RESP

## Operation
- FSM states:
  - IDLE: no operation held.
  - EXEC: operand registers drive the datapath; cvt_en=1.
  - RESP: result held; rsp_valid=1.
- Transitions:
  - IDLE→EXEC on grant.
  - EXEC→RESP unconditionally. cvt_result is captured into rsp_result at this edge.
  - RESP→IDLE on rsp_ready with no new grant.
  - RESP→EXEC on rsp_ready with a same-cycle grant (back-to-back).
  - RESP holds while rsp_ready=0.
- Grant eligibility: state==IDLE, or state==RESP && rsp_ready. Never in EXEC. Never while flush=1.
- reqN_ready = eligible && granted-to-N. Exactly one ready is high when eligible and at least one valid; otherwise both are low.
- Round-robin:
  - 1-bit last_grant pointer; reset value 1, so req0 wins the first contention.
  - If both valid, grant !last_grant. If only one is valid, grant it.
  - Pointer updates only on an accepted grant.
- On grant, the block registers the requester's rs1, rs2_0, funct7_3, tag and the source index.
- Outside EXEC, cvt_en=0 and cvt_rs1/cvt_rs2_0/cvt_funct7_3 are driven to 0, so the datapath output is 0.
- rsp_result, rsp_tag and rsp_src stay stable while rsp_valid && !rsp_ready.
- Flush: the next state is IDLE from any state. Operand and response registers are cleared. rsp_valid=0 from the next cycle. A response handshaking in the flush cycle (rsp_valid&&rsp_ready) still completes. Flush overrides any grant.
- Reset: state IDLE, last_grant=1, all registers 0. Reset mid-EXEC/RESP drops the operation with no response.

## Timing
- Reset values: reqN_ready=0 during reset, cvt_en=0, cvt_* operands 0, rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_src=0, busy=0.
- Accept at edge N → EXEC in cycle N..N+1 → rsp_valid=1 from edge N+2. Latency 2 cycles.
- Maximum throughput is one conversion per 2 cycles. This requires rsp_ready=1 in RESP and a valid request present in that cycle.
- rsp_valid and rsp_* come directly from flops. reqN_ready is combinational from state, valid, rsp_ready, flush and last_grant.

## Structure
- The shared package defines:
  - FSM state enum (IDLE/EXEC/RESP).
  - FCVT op encoding constants {funct7_3, rs2_0}: W_S=00, WU_S=01, S_W=10, S_WU=11.
- One sub-module is natural: fcvt_rr_arb2, a 2-way round-robin arbiter with a pointer that updates on accept.
- The conversion datapath is instantiated outside this block. This block only drives cvt_* and samples cvt_result.

## Test plan
- Single request: req0 with rs1=0x0000_0005, funct7_3=1, rs2_0=0, tag=3 at edge 0 → req0_ready=1 in that cycle. cvt_en=1 and cvt_rs1=5 in cycle 1. rsp_valid=1, rsp_result=cvt_result, rsp_tag=3, rsp_src=0 at edge 2.
- Contention: both valid continuously, rsp_ready=1 → grants alternate 0,1,0,1. One response every 2 cycles, with rsp_src alternating starting at 0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_* stable, both reqN_ready=0, busy=1. Then rsp_ready=1 with req1 valid → same-cycle handshake and grant; next response 2 cycles later.
- Flush in EXEC: accept at edge 0, flush=1 in cycle 1 → no rsp_valid at edge 2, state IDLE, cvt_en=0. A request with flush=0 in cycle 2 is granted.
- Reset mid-RESP: rsp_valid=1, rst_n=0 for one edge → rsp_valid=0, rsp_result=0, last_grant=1. With both then valid, req0 is granted first.
- Datapath idle: no requests for 10 cycles → cvt_en=0, cvt_rs1=0, busy=0, both reqN_ready=0.
